// File: rtl/instr_queue_pkg.sv
// Shared definitions for the instruction issue queue.
//   INSTR_WIDTH_DEF / PC_WIDTH_DEF : default instruction and PC widths
//   instr_t                        : one 32-bit instruction word
//   popcount_prefix()              : number of set bits in a valid vector
//                                    (valid vectors are contiguous prefixes,
//                                    so this equals the prefix length)
package instr_queue_pkg;

    localparam int INSTR_WIDTH_DEF = 32;
    localparam int PC_WIDTH_DEF    = 5;

    typedef logic [31:0] instr_t;

    function automatic logic [5:0] popcount_prefix(input logic [31:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/instr_issue_queue_if.sv
// Bundle of the producer-side and consumer-side signals of the issue queue.
//   slave  : the queue itself (accepts instructions, presents head entries)
//   master : the fetch driver / execute stage surrounding the queue
// Signals: in_valid_i, instr_i, in_ready_o (push side); out_valid_o,
// instr_o, out_pop_i, pc_o (issue side); flush_i, flush_pc_i; count_o.
interface instr_issue_queue_if
    import instr_queue_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int PC_WIDTH    = PC_WIDTH_DEF
);
    localparam int POP_W = $clog2(ISSUE_WIDTH + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_LANES-1:0]               in_valid_i;
    logic [NUM_LANES*INSTR_WIDTH-1:0]   instr_i;
    logic                               in_ready_o;
    logic [ISSUE_WIDTH-1:0]             out_valid_o;
    logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] instr_o;
    logic [POP_W-1:0]                   out_pop_i;
    logic [PC_WIDTH-1:0]                pc_o;
    logic                               flush_i;
    logic [PC_WIDTH-1:0]                flush_pc_i;
    logic [CNT_W-1:0]                   count_o;

    modport slave (
        input  in_valid_i, instr_i, out_pop_i, flush_i, flush_pc_i,
        output in_ready_o, out_valid_o, instr_o, pc_o, count_o
    );

    modport master (
        output in_valid_i, instr_i, out_pop_i, flush_i, flush_pc_i,
        input  in_ready_o, out_valid_o, instr_o, pc_o, count_o
    );

endinterface

// File: rtl/instr_issue_queue_chk.sv
// Simulation checker for the issue queue push interface: the per-lane valid
// vector must be a contiguous prefix starting at lane 0.
//   clk, rst_n  : clock and async active-low reset
//   in_valid_i  : observed per-lane valid vector
module instr_issue_queue_chk #(
    parameter int NUM_LANES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    input logic [NUM_LANES-1:0] in_valid_i
);

    logic [NUM_LANES:0] ext_s;
    logic               contiguous_s;

    // A prefix of ones plus one leaves no bit in common with the original.
    always_comb begin
        ext_s        = {1'b0, in_valid_i};
        contiguous_s = (((ext_s + {{NUM_LANES{1'b0}}, 1'b1}) & ext_s) == '0);
    end

    a_valid_prefix: assert property (@(posedge clk) disable iff (!rst_n) contiguous_s)
        else $error("in_valid_i not a contiguous prefix: %b", in_valid_i);

endmodule

// File: rtl/instr_queue_ram.sv
// Circular storage for the issue queue: DEPTH x INSTR_WIDTH registers with
// NUM_LANES write ports and ISSUE_WIDTH combinational read ports. Lane l of
// each port addresses base + l, wrapping modulo DEPTH (power of two).
//   clk, rst_n  : clock, async active-low reset (clears storage)
//   wr_en_i     : per-lane write enable
//   wr_base_i   : write pointer for lane 0
//   wr_data_i   : packed write data, lane 0 in LSBs
//   rd_base_i   : read pointer for lane 0
//   rd_data_o   : packed read data, lane 0 in LSBs
module instr_queue_ram
    import instr_queue_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_LANES-1:0]               wr_en_i,
    input  logic [PTR_W-1:0]                   wr_base_i,
    input  logic [NUM_LANES*INSTR_WIDTH-1:0]   wr_data_i,
    input  logic [PTR_W-1:0]                   rd_base_i,
    output logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] rd_data_o
);

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_addr_s [NUM_LANES];
    logic [PTR_W-1:0]       rd_addr_s [ISSUE_WIDTH];

    // Per-lane write addresses, wrapping naturally in PTR_W bits.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            wr_addr_s[l] = wr_base_i + PTR_W'(l);
        end
    end

    // Storage update; lanes always hit distinct entries since NUM_LANES <= DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_en_i[l]) begin
                    mem_q[wr_addr_s[l]] <= wr_data_i[l*INSTR_WIDTH +: INSTR_WIDTH];
                end
            end
        end
    end

    // Combinational read of the ISSUE_WIDTH entries starting at the read pointer.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            rd_addr_s[k] = rd_base_i + PTR_W'(k);
            rd_data_o[k*INSTR_WIDTH +: INSTR_WIDTH] = mem_q[rd_addr_s[k]];
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: accepts up to NUM_LANES instructions per cycle
// (all-or-nothing) into a DEPTH-entry circular buffer and presents up to
// ISSUE_WIDTH oldest entries with the PC of the oldest one.
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : push group, issue group, flush/redirect and occupancy
// Optional build macro INSTR_QUEUE_STATS_EN adds:
//   stall_cycles_o  : cycles with lane-0 valid while not ready (saturating)
//   flush_count_o   : number of flush cycles (saturating)
module instr_issue_queue
    import instr_queue_pkg::*;
#(
    parameter int NUM_LANES   = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int PC_WIDTH    = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_issue_queue_if.slave  bus
`ifdef INSTR_QUEUE_STATS_EN
    ,
    output logic [31:0]         stall_cycles_o,
    output logic [15:0]         flush_count_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int POP_W = $clog2(ISSUE_WIDTH + 1);

    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic [CNT_W-1:0]       push_cnt_s;
    logic [CNT_W-1:0]       push_amt_s;
    logic [CNT_W-1:0]       avail_s;
    logic                   ready_s;
    logic                   do_push_s;
    logic [ISSUE_WIDTH-1:0] out_valid_s;
    logic [POP_W-1:0]       occ_s;
    logic [POP_W-1:0]       pop_eff_s;
    logic [NUM_LANES-1:0]   wr_en_s;
    logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] rd_data_s;

    instr_queue_ram #(
        .NUM_LANES   (NUM_LANES),
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .DEPTH       (DEPTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en_s),
        .wr_base_i (wr_ptr_q),
        .wr_data_i (bus.instr_i),
        .rd_base_i (rd_ptr_q),
        .rd_data_o (rd_data_s)
    );

    // Accept/pop decisions; ready comes from the registered count only, so a
    // full queue that pops this cycle still refuses the incoming group.
    always_comb begin
        avail_s    = CNT_W'(DEPTH) - count_q;
        ready_s    = (avail_s >= CNT_W'(NUM_LANES));
        push_cnt_s = CNT_W'(popcount_prefix(32'(bus.in_valid_i)));
        do_push_s  = ready_s && (push_cnt_s != '0) && !bus.flush_i;
        if (do_push_s) begin
            push_amt_s = push_cnt_s;
            wr_en_s    = bus.in_valid_i;
        end else begin
            push_amt_s = '0;
            wr_en_s    = '0;
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            out_valid_s[k] = (count_q > CNT_W'(k));
        end
        occ_s = POP_W'(popcount_prefix(32'(out_valid_s)));
        // Clamp the requested pop to the presented entries: no underflow.
        if (bus.out_pop_i < occ_s) begin
            pop_eff_s = bus.out_pop_i;
        end else begin
            pop_eff_s = occ_s;
        end
    end

    // Next-state for pointers, occupancy and PC; flush overrides push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = bus.flush_pc_i;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff_s);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_amt_s);
            count_d  = count_q + push_amt_s - CNT_W'(pop_eff_s);
            pc_d     = pc_q + PC_WIDTH'(pop_eff_s);
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

    // Output path straight from storage; lanes beyond occupancy read as zero.
    always_comb begin
        bus.instr_o = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (out_valid_s[k]) begin
                bus.instr_o[k*INSTR_WIDTH +: INSTR_WIDTH] = rd_data_s[k*INSTR_WIDTH +: INSTR_WIDTH];
            end else begin
                bus.instr_o[k*INSTR_WIDTH +: INSTR_WIDTH] = '0;
            end
        end
        bus.out_valid_o = out_valid_s;
        bus.in_ready_o  = ready_s;
        bus.pc_o        = pc_q;
        bus.count_o     = count_q;
    end

`ifdef INSTR_QUEUE_STATS_EN
    logic [31:0] stall_q;
    logic [15:0] flush_cnt_q;

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q     <= 32'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (bus.in_valid_i[0] && !ready_s && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (bus.flush_i && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_cnt_q;
`endif

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
- Parametrised successor to the team's two-slot instruction front end.
- Accepts up to NUM_LANES 32-bit instructions per cycle into a circular buffer of DEPTH entries.
- Presents up to ISSUE_WIDTH oldest instructions per cycle to the execute stage, with the PC of the oldest entry.
- Supports pipeline flush with PC redirect; sits between the bench/fetch driver and the processor core.

Parameters:
- NUM_LANES, 2, instruction lanes accepted per cycle.
- ISSUE_WIDTH, 2, instructions presented per cycle.
- DEPTH, 8, queue entries; power of two, ≥ max(NUM_LANES, ISSUE_WIDTH).
- INSTR_WIDTH, 32, instruction width.
- PC_WIDTH, 5, PC counter width; wraps modulo 2^PC_WIDTH.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid_i  input  NUM_LANES  per-lane valid; must be a contiguous prefix from lane 0.
- instr_i  input  NUM_LANES*INSTR_WIDTH  packed instructions; lane 0 in LSBs, lane 0 oldest.
- in_ready_o  output  1  whole group accepted this cycle.
- out_valid_o  output  ISSUE_WIDTH  contiguous prefix, one bit per occupied head entry.
- instr_o  output  ISSUE_WIDTH*INSTR_WIDTH  head entries; lane 0 = oldest.
- out_pop_i  input  $clog2(ISSUE_WIDTH+1)  number of head entries consumed this cycle.
- pc_o  output  PC_WIDTH  PC of oldest queued entry (instr_o lane 0).
- flush_i  input  1  discard all entries.
- flush_pc_i  input  PC_WIDTH  new PC loaded on flush.
- count_o  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async assert, sync deassert internally not required):
  - rd_ptr = wr_ptr = 0, count_o = 0, pc_o = 0, out_valid_o = 0, instr_o = 0.
  - in_ready_o = 1 (DEPTH ≥ NUM_LANES).
- Push count: P = popcount(in_valid_i). A non-contiguous valid pattern is illegal and asserted in simulation; RTL uses popcount.
- Accept rule (all-or-nothing, registered):
  - in_ready_o = (DEPTH − count_o ≥ NUM_LANES), from registered count.
  - Push occurs when in_ready_o & P > 0 & !flush_i.
  - Entries are written lane 0 first at wr_ptr, wr_ptr+1, … modulo DEPTH.
- Pop rule:
  - Effective pop E = min(out_pop_i, popcount(out_valid_o)); no underflow ever.
  - rd_ptr += E; pc_o += E (mod 2^PC_WIDTH, wraps silently).
- Output path:
  - Combinational from storage: out_valid_o[k] = (count_o > k); instr_o lane k = mem[rd_ptr+k].
  - Invalid lanes drive 0.
- Latency: an instruction pushed in cycle N is visible on out_valid_o in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop: count_next = count + P_accepted − E. A full queue popping in the same cycle still presents in_ready_o = 0 that cycle, because ready is a registered-count decision.
- Flush (highest priority):
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0, pc_o = flush_pc_i.
  - Any push or pop in the flush cycle is ignored.
  - in_ready_o stays at its registered value; the dropped push is the producer's responsibility.
- Pointers: $clog2(DEPTH) bits; wrap naturally.
- Reset mid-operation: all state clears immediately; queued contents are lost.

Optional Feature:
- INSTR_QUEUE_STATS_EN defined:
  - Adds outputs stall_cycles_o (32 bit) and flush_count_o (16 bit).
  - stall_cycles_o increments on any cycle with in_valid_i[0] & !in_ready_o.
  - flush_count_o increments per flush_i cycle.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent, and the functional behaviour is otherwise identical.

Decomposition:
- Package instr_queue_pkg:
  - INSTR_WIDTH_DEF = 32, PC_WIDTH_DEF = 5.
  - typedef instr_t (logic[31:0]).
  - function popcount_prefix.
- Sub-module instr_queue_ram: DEPTH × INSTR_WIDTH register file with NUM_LANES write ports and ISSUE_WIDTH read ports, indexed by pointer + offset modulo DEPTH.
- Top-level logic: pointers, count, pc, flush, stats.

Test Plan:
1. Reset, then push 2 instructions (0xAAAA0001, 0xAAAA0002) → next cycle out_valid_o = 2'b11, instr_o lanes match, count_o = 2, pc_o = 0.
2. Fill to DEPTH = 8 with 4 double pushes → count_o = 8, in_ready_o = 0. A fifth push is held off; contents are unchanged.
3. Push 2 and pop 2 every cycle for 20 cycles → count_o constant, pc_o wraps 30 → 0, pointer wrap preserves order.
4. With count_o = 1, drive out_pop_i = 2 → E = 1, count_o = 0, pc_o += 1, no underflow.
5. Queue holding 5, flush_i = 1, flush_pc_i = 5'd17, and simultaneous push → next cycle count_o = 0, pc_o = 17, out_valid_o = 0.
6. Assert rst_n low mid-stream (async, between edges) → outputs immediately at reset values. With INSTR_QUEUE_STATS_EN, stall_cycles_o counts exactly the blocked cycles from scenario 2.
